// File: rtl/seg7_display_pkg.sv
// Shared types and constants for the 7-segment display controller:
// FSM state encoding, active-low glyph table and the all-segments-off code.
package seg7_display_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } seg7_state_t;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is off in every entry.
    localparam logic [7:0] SEG_LUT [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    localparam logic [7:0] BLANK_CODE = 8'hFF;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-segment decoder for one digit (active-low).
// A blanked digit keeps its decimal point under control of dp.
module seg7_hex_decoder
    import seg7_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] code
);

    logic [7:0] glyph;

    assign glyph = blank ? BLANK_CODE : SEG_LUT[nibble];
    assign code  = {~dp, glyph[6:0]};

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment controller: shadowed content with tear-free commit at
// PWM frame boundaries, PWM brightness, leading-zero blanking and per-digit blink.
module seg7_display_ctrl
    import seg7_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BLINK_HZ    = 2,
    parameter int PWM_BITS    = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      LOAD_VALID,
    output logic                      LOAD_READY,
    input  logic [4*NUM_DIGITS-1:0]   VALUE,
    input  logic [NUM_DIGITS-1:0]     DP,
    input  logic                      BLANK_LZ,
    input  logic [NUM_DIGITS-1:0]     BLINK_MASK,
    input  logic [PWM_BITS-1:0]       BRIGHTNESS,
    output logic [8*NUM_DIGITS-1:0]   HEX
);

    localparam int BLINK_HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int PRESC_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(BLINK_HALF - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX    = {PWM_BITS{1'b1}};

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seg7_display_ctrl: NUM_DIGITS must be in 1..8");
    end
    if (CLK_FREQ_HZ < 2 * BLINK_HZ) begin : g_bad_blink_rate
        $error("seg7_display_ctrl: CLK_FREQ_HZ must be >= 2*BLINK_HZ");
    end

    seg7_state_t                state_reg, state_next;
    logic [PWM_BITS-1:0]        pwm_cnt_reg;
    logic [PRESC_W-1:0]         presc_reg;
    logic                       blink_phase_reg;

    logic [4*NUM_DIGITS-1:0]    shadow_value_reg, active_value_reg;
    logic [NUM_DIGITS-1:0]      shadow_dp_reg, active_dp_reg;
    logic [NUM_DIGITS-1:0]      shadow_blink_reg, active_blink_reg;
    logic                       shadow_blank_lz_reg, active_blank_lz_reg;

    logic [8*NUM_DIGITS-1:0]    hex_reg, hex_next;
    logic [NUM_DIGITS-1:0]      blank_vec;
    logic                       lz_run;
    logic                       wrap, shadow_load, commit, lit;

    assign wrap = (pwm_cnt_reg == PWM_MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A wrap seen while IDLE does nothing, so a handshake on a wrap cycle
    // naturally commits one full frame later.
    always_comb begin
        state_next  = state_reg;
        LOAD_READY  = 1'b0;
        shadow_load = 1'b0;
        commit      = 1'b0;
        case (state_reg)
            IDLE: begin
                LOAD_READY = 1'b1;
                if (LOAD_VALID) begin
                    shadow_load = 1'b1;
                    state_next  = PENDING;
                end
            end
            PENDING: begin
                if (wrap) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm_cnt_reg         <= '0;
            presc_reg           <= '0;
            blink_phase_reg     <= 1'b1;
            shadow_value_reg    <= '0;
            shadow_dp_reg       <= '0;
            shadow_blink_reg    <= '0;
            shadow_blank_lz_reg <= 1'b0;
            active_value_reg    <= '0;
            active_dp_reg       <= '0;
            active_blink_reg    <= '0;
            active_blank_lz_reg <= 1'b0;
            hex_reg             <= {(8*NUM_DIGITS){1'b1}};
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            if (presc_reg == PRESC_LAST) begin
                presc_reg       <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
            if (shadow_load) begin
                shadow_value_reg    <= VALUE;
                shadow_dp_reg       <= DP;
                shadow_blink_reg    <= BLINK_MASK;
                shadow_blank_lz_reg <= BLANK_LZ;
            end
            if (commit) begin
                active_value_reg    <= shadow_value_reg;
                active_dp_reg       <= shadow_dp_reg;
                active_blink_reg    <= shadow_blink_reg;
                active_blank_lz_reg <= shadow_blank_lz_reg;
            end
            hex_reg <= hex_next;
        end
    end

    // Blank zeros from the top digit down until the first nonzero nibble.
    always_comb begin
        blank_vec = '0;
        lz_run    = active_blank_lz_reg;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run       = lz_run && (active_value_reg[4*i +: 4] == 4'h0);
            blank_vec[i] = lz_run;
        end
    end

    // Full-scale brightness must stay lit even on the counter's last step.
    assign lit = (BRIGHTNESS == PWM_MAX) || (pwm_cnt_reg < BRIGHTNESS);

    genvar gi;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [7:0] code;

        seg7_hex_decoder u_decoder (
            .nibble (active_value_reg[4*gi +: 4]),
            .dp     (active_dp_reg[gi]),
            .blank  (blank_vec[gi]),
            .code   (code)
        );

        assign hex_next[8*gi +: 8] =
            (lit && !(active_blink_reg[gi] && !blink_phase_reg)) ? code : BLANK_CODE;
    end

    assign HEX = hex_reg;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed self-checking bench for seg7_display_ctrl with a 16-cycle PWM
// frame and a 4-cycle blink half-period.
module tb_seg7_display_ctrl;

    localparam int ND = 6;
    localparam logic [47:0] ALL_OFF   = {48{1'b1}};
    localparam logic [47:0] HEX_0123AF = 48'hC0F9A4B0888E;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          LOAD_VALID = 1'b0;
    logic          LOAD_READY;
    logic [23:0]   VALUE = '0;
    logic [5:0]    DP = '0;
    logic          BLANK_LZ = 1'b0;
    logic [5:0]    BLINK_MASK = '0;
    logic [3:0]    BRIGHTNESS = 4'hF;
    logic [47:0]   HEX;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;

    seg7_display_ctrl #(
        .NUM_DIGITS  (ND),
        .CLK_FREQ_HZ (16),
        .BLINK_HZ    (2),
        .PWM_BITS    (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .VALUE      (VALUE),
        .DP         (DP),
        .BLANK_LZ   (BLANK_LZ),
        .BLINK_MASK (BLINK_MASK),
        .BRIGHTNESS (BRIGHTNESS),
        .HEX        (HEX)
    );

    always #5 CLK = ~CLK;

    // Rising edges since reset release; edges%16 is the PWM count seen at a negedge.
    always @(posedge CLK) begin
        if (RST) edges <= 0;
        else     edges <= edges + 1;
    end

    // Offer content for one cycle; call at a negedge.
    task automatic load(input logic [23:0] v, input logic [5:0] d,
                        input logic blz, input logic [5:0] m);
        VALUE = v; DP = d; BLANK_LZ = blz; BLINK_MASK = m;
        LOAD_VALID = 1'b1;
        @(negedge CLK);
        LOAD_VALID = 1'b0;
    endtask

    // Wait (bounded) for the commit, then one more cycle for HEX to follow.
    task automatic wait_commit(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 40; g++) begin
            @(negedge CLK);
            if (LOAD_READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) @(negedge CLK);
    endtask

    task automatic align_to(input int cnt, output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 40; g++) begin
            if (edges % 16 == cnt) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (HEX !== ALL_OFF) begin
            n_fail++; $display("FAIL reset_hex: got %h expected %h", HEX, ALL_OFF);
        end
        n_checks++;
        if (LOAD_READY !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", LOAD_READY);
        end
        RST = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_decode;
        logic [23:0] vals [3];
        logic [5:0]  dps  [3];
        logic [47:0] exps [3];
        bit ok;
        vals[0] = 24'h0123AF; dps[0] = 6'b000000; exps[0] = HEX_0123AF;
        vals[1] = 24'h456789; dps[1] = 6'b000000; exps[1] = 48'h999282F88090;
        vals[2] = 24'hBCDE00; dps[2] = 6'b100001; exps[2] = 48'h03C6A186C040;
        BRIGHTNESS = 4'hF;
        for (int i = 0; i < 3; i++) begin
            load(vals[i], dps[i], 1'b0, 6'b0);
            n_checks++;
            if (LOAD_READY !== 1'b0) begin
                n_fail++; $display("FAIL decode_ready_drop[%0d]: got %b expected 0", i, LOAD_READY);
            end
            wait_commit(ok);
            n_checks++;
            if (ok !== 1'b1) begin
                n_fail++; $display("FAIL decode_commit_timeout[%0d]: got %b expected 1", i, ok);
            end
            n_checks++;
            if (HEX !== exps[i]) begin
                n_fail++; $display("FAIL decode_hex[%0d]: got %h expected %h", i, HEX, exps[i]);
            end
            $display("decode value=%h dp=%b hex=%h", vals[i], dps[i], HEX);
        end
    endtask

    task automatic test_blank_lz;
        logic [23:0] vals [4];
        logic [5:0]  dps  [4];
        logic [47:0] exps [4];
        bit ok;
        vals[0] = 24'h0123AF; dps[0] = 6'b000000; exps[0] = 48'hFFF9A4B0888E;
        vals[1] = 24'h000000; dps[1] = 6'b000000; exps[1] = 48'hFFFFFFFFFFC0;
        vals[2] = 24'h000000; dps[2] = 6'b100000; exps[2] = 48'h7FFFFFFFFFC0;
        vals[3] = 24'h000100; dps[3] = 6'b000000; exps[3] = 48'hFFFFFFF9C0C0;
        for (int i = 0; i < 4; i++) begin
            load(vals[i], dps[i], 1'b1, 6'b0);
            wait_commit(ok);
            n_checks++;
            if (ok !== 1'b1) begin
                n_fail++; $display("FAIL blank_commit_timeout[%0d]: got %b expected 1", i, ok);
            end
            n_checks++;
            if (HEX !== exps[i]) begin
                n_fail++; $display("FAIL blank_hex[%0d]: got %h expected %h", i, HEX, exps[i]);
            end
            $display("blank_lz value=%h dp=%b hex=%h", vals[i], dps[i], HEX);
        end
    endtask

    task automatic test_brightness;
        bit ok;
        int lit_cycles;
        logic [47:0] exp;
        load(24'h0123AF, 6'b0, 1'b0, 6'b0);
        wait_commit(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL bright_commit_timeout: got %b expected 1", ok);
        end
        BRIGHTNESS = 4'd4;
        @(negedge CLK);
        lit_cycles = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge CLK);
            exp = (((edges - 1) % 16) < 4) ? HEX_0123AF : ALL_OFF;
            if (HEX !== ALL_OFF) lit_cycles++;
            n_checks++;
            if (HEX !== exp) begin
                n_fail++; $display("FAIL bright4_hex[%0d]: got %h expected %h", c, HEX, exp);
            end
        end
        n_checks++;
        if (lit_cycles !== 8) begin
            n_fail++; $display("FAIL bright4_duty: got %0d expected 8", lit_cycles);
        end
        $display("brightness=4 lit %0d of 32 cycles", lit_cycles);
        BRIGHTNESS = 4'd0;
        @(negedge CLK);
        for (int c = 0; c < 32; c++) begin
            @(negedge CLK);
            n_checks++;
            if (HEX !== ALL_OFF) begin
                n_fail++; $display("FAIL bright0_hex[%0d]: got %h expected %h", c, HEX, ALL_OFF);
            end
        end
        $display("brightness=0 hex=%h", HEX);
        BRIGHTNESS = 4'hF;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back;
        bit ok;
        int low;
        align_to(15, ok);
        n_checks++;
        if (ok !== 1'b1 || LOAD_READY !== 1'b1) begin
            n_fail++; $display("FAIL b2b_align: got %b/%b expected 1/1", ok, LOAD_READY);
        end
        // Handshake on the wrap cycle.
        load(24'h456789, 6'b0, 1'b0, 6'b0);
        n_checks++;
        if (LOAD_READY !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ready_after_wrap_hs: got %b expected 0", LOAD_READY);
        end
        // A second offer while pending must be ignored.
        VALUE = 24'hBCDE00; LOAD_VALID = 1'b1;
        low = 1;
        for (int g = 0; g < 40; g++) begin
            @(negedge CLK);
            LOAD_VALID = 1'b0;
            if (LOAD_READY === 1'b0) low++;
            else break;
        end
        n_checks++;
        if (low !== 16) begin
            n_fail++; $display("FAIL b2b_pending_cycles: got %0d expected 16", low);
        end
        n_checks++;
        if (HEX !== HEX_0123AF) begin
            n_fail++; $display("FAIL b2b_hex_before_commit: got %h expected %h", HEX, HEX_0123AF);
        end
        @(negedge CLK);
        n_checks++;
        if (HEX !== 48'h999282F88090) begin
            n_fail++; $display("FAIL b2b_hex_after_commit: got %h expected %h", HEX, 48'h999282F88090);
        end
        $display("back_to_back pending=%0d hex=%h", low, HEX);
    endtask

    task automatic test_blink;
        bit ok;
        logic [47:0] exp;
        load(24'h0123AF, 6'b0, 1'b0, 6'b000001);
        wait_commit(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL blink_commit_timeout: got %b expected 1", ok);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            exp = ((((edges - 1) / 4) % 2) == 0) ? HEX_0123AF : 48'hC0F9A4B088FF;
            n_checks++;
            if (HEX !== exp) begin
                n_fail++; $display("FAIL blink_hex[%0d]: got %h expected %h", c, HEX, exp);
            end
        end
        $display("blink digit0 checked over 16 cycles hex=%h", HEX);
    endtask

    task automatic test_reset_pending;
        bit ok;
        align_to(0, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL rstp_align: got %b expected 1", ok);
        end
        load(24'h456789, 6'b0, 1'b0, 6'b0);
        n_checks++;
        if (LOAD_READY !== 1'b0) begin
            n_fail++; $display("FAIL rstp_pending: got %b expected 0", LOAD_READY);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        #1;
        n_checks++;
        if (HEX !== ALL_OFF) begin
            n_fail++; $display("FAIL rstp_hex_async: got %h expected %h", HEX, ALL_OFF);
        end
        n_checks++;
        if (LOAD_READY !== 1'b1) begin
            n_fail++; $display("FAIL rstp_ready_async: got %b expected 1", LOAD_READY);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        VALUE = 24'hBCDE00; DP = 6'b0; BLANK_LZ = 1'b0; BLINK_MASK = 6'b0;
        LOAD_VALID = 1'b1;
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        n_checks++;
        if (LOAD_READY !== 1'b0) begin
            n_fail++; $display("FAIL rstp_first_edge_accept: got %b expected 0", LOAD_READY);
        end
        n_checks++;
        if (HEX !== 48'hC0C0C0C0C0C0) begin
            n_fail++; $display("FAIL rstp_hex_reset_content: got %h expected %h", HEX, 48'hC0C0C0C0C0C0);
        end
        wait_commit(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++; $display("FAIL rstp_commit_timeout: got %b expected 1", ok);
        end
        n_checks++;
        if (HEX !== 48'h83C6A186C0C0) begin
            n_fail++; $display("FAIL rstp_hex_new_load: got %h expected %h", HEX, 48'h83C6A186C0C0);
        end
        $display("reset_pending hex=%h", HEX);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_blank_lz();
        test_brightness();
        test_back_to_back();
        test_blink();
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
